muldiv_seq: RTL
===============

Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer for the MIPS core: executes mult, multu, div and divu as multi-cycle operations and holds the HI/LO result registers read by mfhi/mflo.
- Sits beside the single-cycle ALU in the execute stage.
- The pipeline controller stalls on busy; results are written only through this block's own HI/LO registers, never through the register file.

Parameters:
XLEN, 32, operand/result width (HI and LO are each XLEN bits)
CNT_W, 6, iteration counter width (must hold XLEN)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  launch operation (sampled only in IDLE)
op  in  2  00 multu, 01 mult, 10 divu, 11 div
src_a  in  XLEN  multiplicand / dividend (rs)
src_b  in  XLEN  multiplier / divisor (rt)
mthi  in  1  write wdata to HI
mtlo  in  1  write wdata to LO
wdata  in  XLEN  data for mthi/mtlo
busy  out  1  operation in progress; pipeline must stall HI/LO users
done  out  1  one-cycle pulse when HI/LO updated by an operation
hi  out  XLEN  HI register (mul: upper product; div: remainder)
lo  out  XLEN  LO register (mul: lower product; div: quotient)

Behaviour:
- One clock: clk. Reset is asynchronous and active-low: rst_n.
- Reset values: state IDLE, busy=0, done=0, hi=0, lo=0, counter=0, internal operand/accumulator registers=0.
- FSM states:
  - IDLE: start=1 latches op, the sign flags and the operand magnitudes, then moves to CALC. Signed ops take two's-complement absolute values; unsigned ops pass operands through. The counter clears.
  - CALC: one bit per cycle, for exactly XLEN cycles.
    - Multiply: shift-add into a 2*XLEN accumulator.
    - Divide: restoring shift-subtract using a single XLEN+1-bit subtractor.
    - counter==XLEN-1 moves the FSM to FIX.
  - FIX: applies sign correction, writes hi/lo, sets done<=1, returns to IDLE.
    - mult: 2*XLEN product is negated if the operand signs differ.
    - div: quotient is negated if the signs differ; remainder takes the sign of the dividend.
- Latency: start sampled at edge E0; busy=1 from E0 until E33 (33 cycles); hi/lo updated and done=1 from E33 to E34. busy is derived from registered state (CALC or FIX), no combinational path from start.
- start while busy: ignored, with no effect on the operation in flight.
- start in the done cycle (state IDLE): accepted; hi/lo keep the new result until the next FIX.
- mthi/mtlo: honoured only in IDLE with start=0; they write on the next edge. If both are asserted, both registers get wdata. When busy, or when start=1 in the same cycle, they are ignored.
- Divide by zero (src_b==0, div or divu): the full latency is kept; result is hi=src_a (original, unsigned view), lo=all ones.
- Signed overflow (div, 0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0. This falls out of the magnitude algorithm with no special case.
- Arithmetic: intermediate product is 2*XLEN bits; the divide partial remainder is XLEN+1 bits; all wrap is modulo 2^XLEN on output.
- Reset mid-operation: immediate abort; all outputs return to reset values and no done pulse is issued.

Decomposition:
- Shared package muldiv_pkg holds:
  - op encodings OP_MULTU/OP_MULT/OP_DIVU/OP_DIV;
  - FSM state encoding S_IDLE/S_CALC/S_FIX;
  - XLEN default.
- The datapath stays inline. One natural sub-module, muldiv_negate (conditional two's-complement negate, parameterised width), is instantiated for operand abs and result fixup.

Test Plan:
- multu 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; busy high exactly 33 cycles; done one-cycle pulse on the 33rd edge after start.
- mult -3 x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. mult 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
- divu 100 / 7 -> lo=14, hi=2. div -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. div 7 / -2 -> lo=0xFFFFFFFD, hi=1.
- divu 5 / 0 -> hi=5, lo=0xFFFFFFFF. div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- During an op: pulse start with new operands and mthi=1, wdata=0x1234 -> both ignored, original result delivered. In IDLE: mthi wdata=0x1234 -> hi=0x1234 next edge, lo unchanged.
- Assert rst_n=0 at cycle 10 of a multu -> busy=0, done never pulses, hi=lo=0. Then back-to-back multu 3x4 with start asserted in the done cycle of the first -> second result hi=0, lo=12 after a further 33 cycles.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide sequencer.
package muldiv_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int CNT_W_DEF = 6;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } state_e;

    function automatic logic op_is_div(input op_e o);
        return (o == OP_DIVU) || (o == OP_DIV);
    endfunction

    function automatic logic op_is_signed(input op_e o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fixup.
module muldiv_negate #(
    parameter int W = 32
) (
    input  logic [W-1:0] in_val,
    input  logic         neg,
    output logic [W-1:0] out_val
);

    assign out_val = neg ? (~in_val + {{(W-1){1'b0}}, 1'b1}) : in_val;

endmodule

// File: rtl/muldiv_seq.sv
// Iterative mult/multu/div/divu sequencer owning the HI/LO registers.
// Operates on magnitudes for one bit per cycle, then fixes signs in a final cycle.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            mthi,
    input  logic            mtlo,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    state_e                state_q, state_d;
    op_e                   op_q, op_d;
    logic                  neg_res_q, neg_res_d;
    logic                  neg_rem_q, neg_rem_d;
    logic                  dz_q, dz_d;
    logic [XLEN-1:0]       opnd_q, opnd_d;
    logic [2*XLEN-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [XLEN-1:0]       hi_q, hi_d;
    logic [XLEN-1:0]       lo_q, lo_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;

    logic                  sign_a_s, sign_b_s;
    logic [XLEN-1:0]       abs_a_s, abs_b_s;
    logic [2*XLEN-1:0]     prod_s;
    logic [XLEN-1:0]       quot_s, rem_s;
    logic [XLEN:0]         mul_sum_s;
    logic [2*XLEN-1:0]     mul_next_s;
    logic [XLEN:0]         div_diff_s;
    logic                  div_ge_s;
    logic [XLEN-1:0]       div_rem_s;
    logic [2*XLEN-1:0]     div_next_s;

    assign sign_a_s = op_is_signed(op_e'(op)) & src_a[XLEN-1];
    assign sign_b_s = op_is_signed(op_e'(op)) & src_b[XLEN-1];

    muldiv_negate #(.W(XLEN)) u_abs_a (.in_val(src_a), .neg(sign_a_s), .out_val(abs_a_s));
    muldiv_negate #(.W(XLEN)) u_abs_b (.in_val(src_b), .neg(sign_b_s), .out_val(abs_b_s));

    // A zero divisor must leave the all-ones quotient untouched by the sign fixup.
    muldiv_negate #(.W(2*XLEN)) u_prod_fix (.in_val(acc_q), .neg(neg_res_q), .out_val(prod_s));
    muldiv_negate #(.W(XLEN)) u_quot_fix (
        .in_val (acc_q[XLEN-1:0]),
        .neg    (neg_res_q & ~dz_q),
        .out_val(quot_s)
    );
    muldiv_negate #(.W(XLEN)) u_rem_fix (
        .in_val (acc_q[2*XLEN-1:XLEN]),
        .neg    (neg_rem_q),
        .out_val(rem_s)
    );

    // Multiply step: acc = {partial product, remaining multiplier bits}, shifted right.
    assign mul_sum_s  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : {XLEN{1'b0}})};
    assign mul_next_s = {mul_sum_s, acc_q[XLEN-1:1]};

    // Divide step: acc = {partial remainder, dividend/quotient}; the remainder stays below
    // the divisor, so the sign of the XLEN+1-bit difference is the restore decision.
    assign div_diff_s = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]} - {1'b0, opnd_q};
    assign div_ge_s   = ~div_diff_s[XLEN];
    assign div_rem_s  = div_ge_s ? div_diff_s[XLEN-1:0]
                                 : {acc_q[2*XLEN-2:XLEN], acc_q[XLEN-1]};
    assign div_next_s = {div_rem_s, acc_q[XLEN-2:0], div_ge_s};

    // Next-state, datapath and HI/LO update logic.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d      = op_e'(op);
                    neg_res_d = sign_a_s ^ sign_b_s;
                    neg_rem_d = sign_a_s;
                    dz_d      = op_is_div(op_e'(op)) & (src_b == {XLEN{1'b0}});
                    opnd_d    = op_is_div(op_e'(op)) ? abs_b_s : abs_a_s;
                    acc_d     = op_is_div(op_e'(op)) ? {{XLEN{1'b0}}, abs_a_s}
                                                     : {{XLEN{1'b0}}, abs_b_s};
                    cnt_d     = {CNT_W{1'b0}};
                    state_d   = S_CALC;
                end else begin
                    if (mthi) hi_d = wdata;
                    if (mtlo) lo_d = wdata;
                end
            end
            S_CALC: begin
                acc_d = op_is_div(op_q) ? div_next_s : mul_next_s;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    state_d = S_FIX;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_FIX: begin
                if (op_is_div(op_q)) begin
                    hi_d = rem_s;
                    lo_d = quot_s;
                end else begin
                    hi_d = prod_s[2*XLEN-1:XLEN];
                    lo_d = prod_s[XLEN-1:0];
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= OP_MULTU;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            opnd_q    <= {XLEN{1'b0}};
            acc_q     <= {(2*XLEN){1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            hi_q      <= {XLEN{1'b0}};
            lo_q      <= {XLEN{1'b0}};
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
